// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding,
// handshake byte values and the word-alignment helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX99    = 3'd1,
        ST_RX_SIZE = 3'd2,
        ST_RX_BODY = 3'd3,
        ST_TXAA    = 3'd4,
        ST_HOLD    = 3'd5
    } loader_state_e;

    localparam logic [7:0] BOOT_ACK_BYTE  = 8'h99;
    localparam logic [7:0] BOOT_DONE_BYTE = 8'hAA;
    localparam int         WORD_BYTES     = 4;

    // Left-align a right-aligned word holding nbytes bytes (nbytes==0 means a full word).
    function automatic logic [31:0] left_align(input logic [31:0] w, input logic [1:0] nbytes);
        logic [1:0] pad;
        pad = 2'd0 - nbytes;
        return w << {pad, 3'b000};
    endfunction

endpackage

// File: rtl/program_loader_byte_to_word_assembler.sv
// Packs a byte stream big-endian into 32-bit words. A flush on the final byte
// emits a partial word left-aligned with zero padding in the low bytes.
module program_loader_byte_to_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        flush_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [31:0] shift_next_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_q, word_d;
    logic [31:0] shift_next;

    assign shift_next   = {shift_q[23:0], byte_i};
    assign shift_next_o = shift_next;
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    // Next-state: shift in a byte, emit a word on the 4th byte or on flush.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (push_i) begin
            if (cnt_q == 2'(WORD_BYTES - 1) || flush_i) begin
                word_valid_d = 1'b1;
                word_d       = left_align(shift_next, cnt_q + 2'd1);
                shift_d      = '0;
                cnt_d        = '0;
            end else begin
                shift_d = shift_next;
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: answers the CPU's boot-phase request levels by sending the
// handshake bytes, parsing the program size and streaming the program body
// into instruction memory as big-endian 32-bit words.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 14,
    parameter int SIZE_BYTES      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       transmit_0x99,
    input  logic                       receive_program_data_size,
    input  logic                       receive_program_data,
    input  logic                       transmit_0xAA,
    output logic                       transmit_0x99_finished,
    output logic                       receive_program_data_size_finished,
    output logic                       receive_program_data_finished,
    output logic                       transmit_0xAA_finished,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [IMEM_ADDR_WIDTH:0]   program_words,
    output logic                       overflow
);

    loader_state_e              state_q, state_d, phase_q;
    logic [31:0]                size_q, byte_cnt_q;
    logic [IMEM_ADDR_WIDTH:0]   addr_q;
    logic                       body_last_q, overflow_q;

    logic        asm_clear, asm_push, asm_flush, asm_word_valid;
    logic [31:0] asm_word, asm_shift_next;
    logic        size_push, size_last, body_push, body_is_last;
    logic        addr_full, word_slot, hold_req;

    // Phase entry clears partial state so aborted phases leave nothing behind.
    assign asm_clear    = (state_q == ST_IDLE) &&
                          (state_d == ST_RX_SIZE || state_d == ST_RX_BODY);
    assign size_push    = (state_q == ST_RX_SIZE) && rx_valid;
    assign size_last    = (byte_cnt_q == 32'(SIZE_BYTES - 1));
    assign body_push    = (state_q == ST_RX_BODY) && rx_valid && (size_q != 32'd0) && !body_last_q;
    assign body_is_last = (byte_cnt_q == size_q - 32'd1);
    assign asm_push     = size_push || body_push;
    assign asm_flush    = body_push && body_is_last;
    assign addr_full    = addr_q[IMEM_ADDR_WIDTH];
    assign word_slot    = (state_q == ST_RX_BODY) && asm_word_valid;

    program_loader_byte_to_word_assembler u_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (asm_clear),
        .push_i       (asm_push),
        .flush_i      (asm_flush),
        .byte_i       (rx_data),
        .word_valid_o (asm_word_valid),
        .word_o       (asm_word),
        .shift_next_o (asm_shift_next)
    );

    // Request level belonging to the phase currently being acknowledged.
    always_comb begin
        hold_req = 1'b0;
        case (phase_q)
            ST_TX99:    hold_req = transmit_0x99;
            ST_RX_SIZE: hold_req = receive_program_data_size;
            ST_RX_BODY: hold_req = receive_program_data;
            ST_TXAA:    hold_req = transmit_0xAA;
            default:    hold_req = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: priority dispatch, abort on dropped request, hold until release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if      (transmit_0x99)             state_d = ST_TX99;
                else if (receive_program_data_size) state_d = ST_RX_SIZE;
                else if (receive_program_data)      state_d = ST_RX_BODY;
                else if (transmit_0xAA)             state_d = ST_TXAA;
            end
            ST_TX99: begin
                if      (!transmit_0x99) state_d = ST_IDLE;
                else if (tx_ready)       state_d = ST_HOLD;
            end
            ST_RX_SIZE: begin
                if      (!receive_program_data_size) state_d = ST_IDLE;
                else if (size_push && size_last)     state_d = ST_HOLD;
            end
            ST_RX_BODY: begin
                if      (!receive_program_data)         state_d = ST_IDLE;
                else if (size_q == 32'd0 || body_last_q) state_d = ST_HOLD;
            end
            ST_TXAA: begin
                if      (!transmit_0xAA) state_d = ST_IDLE;
                else if (tx_ready)       state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!hold_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: size capture, byte counting, word addressing and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q     <= ST_IDLE;
            size_q      <= '0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            body_last_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (state_d == ST_HOLD && state_q != ST_HOLD) phase_q <= state_q;
            if (asm_clear) byte_cnt_q <= '0;
            if (state_q == ST_IDLE && state_d == ST_RX_BODY) begin
                addr_q      <= '0;
                body_last_q <= 1'b0;
            end
            if (size_push) begin
                byte_cnt_q <= byte_cnt_q + 32'd1;
                if (size_last) size_q <= asm_shift_next;
            end
            if (body_push) begin
                byte_cnt_q <= byte_cnt_q + 32'd1;
                if (body_is_last) body_last_q <= 1'b1;
            end
            if (word_slot) begin
                if (addr_full) overflow_q <= 1'b1;
                else           addr_q     <= addr_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state, acknowledged phase and the assembler strobe.
    always_comb begin
        tx_valid                           = 1'b0;
        tx_data                            = 8'h00;
        transmit_0x99_finished             = 1'b0;
        receive_program_data_size_finished = 1'b0;
        receive_program_data_finished      = 1'b0;
        transmit_0xAA_finished             = 1'b0;
        case (state_q)
            ST_TX99: begin
                tx_valid = 1'b1;
                tx_data  = BOOT_ACK_BYTE;
            end
            ST_TXAA: begin
                tx_valid = 1'b1;
                tx_data  = BOOT_DONE_BYTE;
            end
            ST_HOLD: begin
                transmit_0x99_finished             = (phase_q == ST_TX99);
                receive_program_data_size_finished = (phase_q == ST_RX_SIZE);
                receive_program_data_finished      = (phase_q == ST_RX_BODY);
                transmit_0xAA_finished             = (phase_q == ST_TXAA);
            end
            default: ;
        endcase
        imem_we       = word_slot && !addr_full;
        imem_addr     = addr_q[IMEM_ADDR_WIDTH-1:0];
        imem_wdata    = imem_we ? asm_word : 32'd0;
        program_words = addr_q;
        overflow      = overflow_q;
    end

endmodule
